seg7_scan_drv: RTL

Multiplexed 7-segment display driver for the watch's hh:mm readout. It takes the four fully encoded digit codes produced by the minute and hour counter chain and decodes each one to segment patterns. It time-multiplexes the four digits onto a shared segment bus with one-hot digit enables, and inserts a blanking gap between digits to suppress ghosting. It sits between the counter chain and the chip's display pads.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_drv_if.sv | 12 +
 rtl/seg7_dec.sv | 27 ++
 rtl/seg7_scan_drv.sv | 95 +++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the hh:mm 7-segment display path.
package seg7_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit positions on the display.
    localparam logic [1:0] MIN_U = 2'd0;
    localparam logic [1:0] MIN_T = 2'd1;
    localparam logic [1:0] HR_U  = 2'd2;
    localparam logic [1:0] HR_T  = 2'd3;

    // Per-slot phase: dark gap first, then the digit is lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_scan_drv_if.sv
// Digit bundle from the minute/hour counter chain to the display driver.
interface seg7_scan_drv_if;
    logic [3:0] digit0;   // minute units
    logic [3:0] digit1;   // minute tens
    logic [3:0] digit2;   // hour units
    logic [3:0] digit3;   // hour tens
    logic       lz_en;    // blank a zero hour-tens digit
    logic       colon;    // colon request, level

    modport master (output digit0, digit1, digit2, digit3, lz_en, colon);
    modport slave  (input  digit0, digit1, digit2, digit3, lz_en, colon);
endinterface

// File: rtl/seg7_dec.sv
// BCD digit code to 7-segment pattern; codes 10..15 render as a dash.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Pure lookup; anything outside 0..9 falls through to the dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed 7-segment scan driver with inter-digit blanking.
// A snapshot of all digits is taken at the start of each frame so the
// four slots of a frame always show one coherent time value.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int SCAN_CYC  = 250,
    parameter int BLANK_CYC = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    seg7_scan_drv_if.slave        dig_if,
    output logic [6:0]            seg_o,
    output logic [3:0]            an_o,
    output logic                  dp_o
);

    localparam int             CW         = $clog2(SCAN_CYC);
    localparam logic [CW-1:0]  CNT_MAX    = CW'(SCAN_CYC - 1);
    localparam logic [CW-1:0]  CNT_PRE_SH = CW'(BLANK_CYC - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    slot_state_e      state_q;
    logic [3:0][3:0]  snap_q;
    logic             lz_q, colon_q;

    logic             wrap, snap_en, lz_blank;
    logic [3:0]       cur_code;
    logic [6:0]       dec_seg;

    // Slot/digit sequencing and selection of the digit being shown.
    always_comb begin
        wrap     = (cnt_q == CNT_MAX);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        snap_en  = (cnt_q == '0) && (idx_q == MIN_U);
        cur_code = snap_q[idx_q];
        lz_blank = lz_q && (idx_q == HR_T) && (cur_code == 4'd0);
    end

    seg7_dec u_dec (
        .code_i (cur_code),
        .seg_o  (dec_seg)
    );

    // Capture the whole display value once per frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q  <= '0;
            lz_q    <= 1'b0;
            colon_q <= 1'b0;
        end else if (snap_en) begin
            snap_q[MIN_U] <= dig_if.digit0;
            snap_q[MIN_T] <= dig_if.digit1;
            snap_q[HR_U]  <= dig_if.digit2;
            snap_q[HR_T]  <= dig_if.digit3;
            lz_q          <= dig_if.lz_en;
            colon_q       <= dig_if.colon;
        end
    end

    // Counters, BLANK/SHOW FSM and registered pad outputs. state_q is
    // SHOW exactly while cnt_q >= BLANK_CYC, so outputs lag (cnt, idx)
    // by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= MIN_U;
            state_q <= ST_BLANK;
            seg_o   <= SEG_BLANK;
            an_o    <= 4'b0000;
            dp_o    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            case (state_q)
                ST_BLANK: begin
                    seg_o <= SEG_BLANK;
                    an_o  <= 4'b0000;
                    dp_o  <= 1'b0;
                    if (cnt_q == CNT_PRE_SH) state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    seg_o <= lz_blank ? SEG_BLANK : dec_seg;
                    an_o  <= 4'b0001 << idx_q;
                    dp_o  <= colon_q && (idx_q == HR_U);
                    if (wrap) state_q <= ST_BLANK;
                end
                default: state_q <= ST_BLANK;
            endcase
        end
    end

endmodule
